integ: RTL



---
 rtl/integ_pkg.sv | 44 ++++
 rtl/integ_prefix8.sv | 69 ++++++
 rtl/integ.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/integ_pkg.sv
// Shared types and constants for the lane-parallel integrator (inverse differentiator).
`timescale 1ns/1ps
package integ_pkg;

    localparam int SAMPLE_WIDTH = 32;
    localparam int LANE_W       = SAMPLE_WIDTH / 2;
    localparam int NUM          = 8;
    localparam int ACC_WIDTH    = 24;
    localparam int PIPE_LAT     = 5;

    typedef logic signed [LANE_W-1:0]    lane_t;
    typedef logic signed [ACC_WIDTH-1:0] acc_t;

    // Sideband that travels with each beat through every pipeline stage.
    typedef struct packed {
        logic valid;
        logic last;
        logic first;
        logic mode;
    } side_t;

    typedef struct packed {
        lane_t value;
        logic  clip;
    } sat_t;

    localparam acc_t LANE_MAX = acc_t'(32767);
    localparam acc_t LANE_MIN = acc_t'(-32768);

    function automatic sat_t sat16(input acc_t v);
        sat_t r;
        r.value = v[LANE_W-1:0];
        r.clip  = 1'b0;
        if (v > LANE_MAX) begin
            r.value = 16'sh7FFF;
            r.clip  = 1'b1;
        end else if (v < LANE_MIN) begin
            r.value = 16'sh8000;
            r.clip  = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/integ_prefix8.sv
// Three registered levels of an 8-lane prefix-sum tree; stride 1 (real) or 2 (complex I/Q).
`timescale 1ns/1ps
module integ_prefix8 import integ_pkg::*; (
    input  logic             clk,
    input  logic             rst,
    input  acc_t [NUM-1:0]   i_p,
    input  side_t            i_side,
    output acc_t [NUM-1:0]   o_p,
    output side_t            o_side
);

    acc_t [NUM-1:0] s2_p_d, s2_p_q;
    acc_t [NUM-1:0] s3_p_d, s3_p_q;
    acc_t [NUM-1:0] s4_p_d, s4_p_q;
    side_t          s2_side_d, s2_side_q;
    side_t          s3_side_d, s3_side_q;
    side_t          s4_side_d, s4_side_q;

    always_comb begin
        s2_side_d = i_side;
        s2_p_d    = i_p;
        if (i_side.mode) begin
            for (int k = 1; k < NUM; k++) s2_p_d[k] = i_p[k] + i_p[k-1];
        end else begin
            for (int k = 2; k < NUM; k++) s2_p_d[k] = i_p[k] + i_p[k-2];
        end
    end

    always_comb begin
        s3_side_d = s2_side_q;
        s3_p_d    = s2_p_q;
        if (s2_side_q.mode) begin
            for (int k = 2; k < NUM; k++) s3_p_d[k] = s2_p_q[k] + s2_p_q[k-2];
        end else begin
            for (int k = 4; k < NUM; k++) s3_p_d[k] = s2_p_q[k] + s2_p_q[k-4];
        end
    end

    // Complex lanes are fully summed after two levels, so the third level is real-only.
    always_comb begin
        s4_side_d = s3_side_q;
        s4_p_d    = s3_p_q;
        if (s3_side_q.mode) begin
            for (int k = 4; k < NUM; k++) s4_p_d[k] = s3_p_q[k] + s3_p_q[k-4];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_side_q <= '0;
            s3_side_q <= '0;
            s4_side_q <= '0;
            s2_p_q    <= '0;
            s3_p_q    <= '0;
            s4_p_q    <= '0;
        end else begin
            s2_side_q <= s2_side_d;
            s3_side_q <= s3_side_d;
            s4_side_q <= s4_side_d;
            if (s2_side_d.valid) s2_p_q <= s2_p_d;
            if (s3_side_d.valid) s3_p_q <= s3_p_d;
            if (s4_side_d.valid) s4_p_q <= s4_p_d;
        end
    end

    assign o_p    = s4_p_q;
    assign o_side = s4_side_q;

endmodule

// File: rtl/integ.sv
// Lane-parallel integrator: rebuilds samples from first differences across lanes and beats.
`timescale 1ns/1ps
module integ import integ_pkg::*; (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_switch,
    input  lane_t [NUM-1:0]   i_x0_data,
    input  logic              i_x0_valid,
    input  logic              i_x0_last,
    output lane_t [NUM-1:0]   o_y0,
    output logic              o_y0_valid,
    output logic              o_y0_last,
    output logic              o_sat
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t         state_d, state_q;
    logic           mode_d, mode_q;
    logic           beat_first;
    logic           beat_mode;

    side_t          s1_side_d, s1_side_q;
    acc_t [NUM-1:0] s1_p_d, s1_p_q;

    acc_t [NUM-1:0] pf_p;
    side_t          pf_side;

    acc_t           carry_i_d, carry_i_q;
    acc_t           carry_q_d, carry_q_q;
    acc_t           base_i, base_q;
    acc_t [NUM-1:0] y_acc;
    sat_t [NUM-1:0] y_sat;
    logic           clip_any;

    lane_t [NUM-1:0] y_d, y_q;
    logic           y_valid_d, y_valid_q;
    logic           y_last_d, y_last_q;
    logic           sat_d, sat_q;

    // Mode is captured on the first beat of a frame and reused for every later beat.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        beat_first = 1'b0;
        beat_mode  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (i_x0_valid) begin
                    beat_first = 1'b1;
                    beat_mode  = i_switch;
                    mode_d     = i_switch;
                    state_d    = i_x0_last ? ST_IDLE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_x0_valid && i_x0_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s1_side_d.valid = i_x0_valid;
        s1_side_d.last  = i_x0_valid & i_x0_last;
        s1_side_d.first = beat_first;
        s1_side_d.mode  = beat_mode;
        for (int k = 0; k < NUM; k++) begin
            s1_p_d[k] = {{(ACC_WIDTH-LANE_W){i_x0_data[k][LANE_W-1]}}, i_x0_data[k]};
        end
    end

    integ_prefix8 u_prefix (
        .clk    (clk),
        .rst    (rst),
        .i_p    (s1_p_q),
        .i_side (s1_side_q),
        .o_p    (pf_p),
        .o_side (pf_side)
    );

    // Carries restart when a frame's first beat arrives here, so back-to-back frames never mix.
    always_comb begin
        base_i   = pf_side.first ? '0 : carry_i_q;
        base_q   = pf_side.first ? '0 : carry_q_q;
        y_acc    = '0;
        y_sat    = '0;
        clip_any = 1'b0;
        for (int k = 0; k < NUM; k++) begin
            if (pf_side.mode || ((k % 2) == 0)) y_acc[k] = base_i + pf_p[k];
            else                                y_acc[k] = base_q + pf_p[k];
            y_sat[k] = sat16(y_acc[k]);
            clip_any = clip_any | y_sat[k].clip;
        end

        carry_i_d = carry_i_q;
        carry_q_d = carry_q_q;
        y_d       = y_q;
        y_valid_d = 1'b0;
        y_last_d  = 1'b0;
        sat_d     = sat_q;
        if (pf_side.valid) begin
            if (pf_side.mode) begin
                carry_i_d = base_i + pf_p[NUM-1];
                carry_q_d = base_q;
            end else begin
                carry_i_d = base_i + pf_p[NUM-2];
                carry_q_d = base_q + pf_p[NUM-1];
            end
            for (int k = 0; k < NUM; k++) y_d[k] = y_sat[k].value;
            y_valid_d = 1'b1;
            y_last_d  = pf_side.last;
            sat_d     = pf_side.first ? clip_any : (sat_q | clip_any);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mode_q    <= 1'b0;
            s1_side_q <= '0;
            s1_p_q    <= '0;
            carry_i_q <= '0;
            carry_q_q <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            y_last_q  <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            s1_side_q <= s1_side_d;
            if (s1_side_d.valid) s1_p_q <= s1_p_d;
            carry_i_q <= carry_i_d;
            carry_q_q <= carry_q_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            y_last_q  <= y_last_d;
            sat_q     <= sat_d;
        end
    end

    assign o_y0       = y_q;
    assign o_y0_valid = y_valid_q;
    assign o_y0_last  = y_last_q;
    assign o_sat      = sat_q;

endmodule
